// File: rtl/sram_stream_pkg.sv
// sram_stream_pkg : shared types and region helpers for the SRAM stream controller (rev 1.0)
`default_nettype none

package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    W_STREAM = 2'd1,
    I_STREAM = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  typedef enum logic {
    REG_WEIGHT = 1'b0,
    REG_INPUT  = 1'b1
  } region_t;

  // Row offset of a region inside every bank: weights low half, inputs high half.
  function automatic int unsigned region_base(region_t region, int unsigned depth);
    return (region == REG_INPUT) ? depth / 2 : 0;
  endfunction

  // Words one region holds when striped across all banks.
  function automatic int unsigned region_cap(int unsigned num_banks, int unsigned depth);
    return num_banks * depth / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank.sv
// sram_bank : single-port DEPTH x DATA_W bank with a 1-cycle registered read (rev 1.0)
`default_nettype none

module sram_bank #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl : banked weight/input store streaming to the systolic array (rev 1.0)
`default_nettype none

module sram_stream_ctrl
  import sram_stream_pkg::*;
#(
  parameter  int NUM_BANKS = 8,
  parameter  int DATA_W    = 64,
  parameter  int DEPTH     = 1024,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(NUM_BANKS*DEPTH/2)+1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_type,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              reuse_weights,
  input  logic              clear_weights,
  output logic              busy,
  output logic              weights_done,
  output logic              inputs_done,
  output logic              occupancy_err,
  output logic [CNT_W-1:0]  w_count,
  output logic [CNT_W-1:0]  i_count,
  output logic              strm_valid,
  input  logic              strm_ready,
  output logic [DATA_W-1:0] strm_data,
  output logic              strm_is_weight
);

  localparam int             BANK_W   = $clog2(NUM_BANKS);
  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(region_cap(NUM_BANKS, DEPTH));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_w_count, r_i_count, r_rd_idx;
  logic                r_inflight, r_rd_is_w, r_rd_last;
  logic [BANK_W-1:0]   r_rd_bank;
  logic [DATA_W-1:0]   r_buf_data [2];
  logic [1:0]          r_buf_w, r_buf_last;
  logic                r_head, r_tail;
  logic [1:0]          r_cnt;
  logic                r_idle_done;

  logic                w_idle, w_load_hs, w_full, w_we, w_pop, w_have, w_room, w_issue, w_rd_last;
  logic [CNT_W-1:0]    w_load_cnt, w_rd_count;
  region_t             w_load_region, w_rd_region;
  logic [ADDR_W-1:0]   w_load_row, w_rd_row, w_addr;
  logic [2:0]          w_occ;
  logic [DATA_W-1:0]   w_bank_rdata [NUM_BANKS];

  // Load side: only while idle, and a start in the same cycle takes precedence.
  assign w_idle        = (r_state == IDLE);
  assign load_ready    = n_rst && w_idle && !start;
  assign w_load_hs     = load_valid && load_ready;
  assign w_load_region = region_t'(load_type);
  assign w_load_cnt    = load_type ? r_i_count : r_w_count;
  assign w_full        = (w_load_cnt == CAP_C);
  assign w_we          = w_load_hs && !w_full && !(clear_weights && !load_type);
  assign occupancy_err = w_load_hs && w_full;
  assign w_load_row    = ADDR_W'(region_base(w_load_region, DEPTH)) + ADDR_W'(w_load_cnt >> BANK_W);

  // Read side: a pop this cycle frees a slot, which keeps one word per cycle flowing.
  assign w_pop       = strm_valid && strm_ready;
  assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room      = (w_occ < 3'd2);
  assign w_have      = (r_state == W_STREAM) || ((r_state == I_STREAM) && (r_i_count != '0));
  assign w_issue     = w_have && w_room;
  assign w_rd_count  = (r_state == W_STREAM) ? r_w_count : r_i_count;
  assign w_rd_last   = ((r_rd_idx + CNT_ONE) == w_rd_count);
  assign w_rd_region = (r_state == W_STREAM) ? REG_WEIGHT : REG_INPUT;
  assign w_rd_row    = ADDR_W'(region_base(w_rd_region, DEPTH)) + ADDR_W'(r_rd_idx >> BANK_W);
  assign w_addr      = w_idle ? w_load_row : w_rd_row;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic w_bank_we, w_bank_re;
    assign w_bank_we = w_we && (w_load_cnt[BANK_W-1:0] == BANK_W'(b));
    assign w_bank_re = w_issue && (r_rd_idx[BANK_W-1:0] == BANK_W'(b));

    sram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (w_bank_we),
      .re    (w_bank_re),
      .addr  (w_addr),
      .wdata (load_data),
      .rdata (w_bank_rdata[b])
    );
  end

  assign busy           = (r_state != IDLE);
  assign w_count        = r_w_count;
  assign i_count        = r_i_count;
  assign strm_valid     = (r_cnt != 2'd0);
  assign strm_data      = r_buf_data[r_head];
  assign strm_is_weight = r_buf_w[r_head];
  assign weights_done   = w_pop && r_buf_w[r_head] && r_buf_last[r_head];
  assign inputs_done    = (w_pop && !r_buf_w[r_head] && r_buf_last[r_head]) || r_idle_done;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_w_count     <= '0;
      r_i_count     <= '0;
      r_rd_idx      <= '0;
      r_inflight    <= 1'b0;
      r_rd_bank     <= '0;
      r_rd_is_w     <= 1'b0;
      r_rd_last     <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_w       <= '0;
      r_buf_last    <= '0;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_cnt         <= 2'd0;
      r_idle_done   <= 1'b0;
    end else begin
      r_idle_done <= 1'b0;

      // Bank data lands in the skid buffer one cycle after its read was issued.
      if (r_inflight) begin
        r_buf_data[r_tail] <= w_bank_rdata[r_rd_bank];
        r_buf_w[r_tail]    <= r_rd_is_w;
        r_buf_last[r_tail] <= r_rd_last;
        r_tail             <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;

      if (w_issue) begin
        r_rd_bank <= r_rd_idx[BANK_W-1:0];
        r_rd_is_w <= (r_state == W_STREAM);
        r_rd_last <= w_rd_last;
        r_rd_idx  <= w_rd_last ? '0 : r_rd_idx + CNT_ONE;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_rd_idx <= '0;
            r_state  <= (!reuse_weights && (r_w_count != '0)) ? W_STREAM : I_STREAM;
          end else begin
            if (clear_weights)         r_w_count <= '0;
            else if (w_we && !load_type) r_w_count <= r_w_count + CNT_ONE;
            if (w_we && load_type)     r_i_count <= r_i_count + CNT_ONE;
          end
        end
        W_STREAM: begin
          if (w_issue && w_rd_last) r_state <= I_STREAM;
        end
        I_STREAM: begin
          // No inputs: finish straight away if nothing is left from the weight phase.
          if (r_i_count == '0) begin
            if ((r_cnt == 2'd0) && !r_inflight) begin
              r_state     <= IDLE;
              r_idle_done <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else if (w_issue && w_rd_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((r_cnt == 2'd0) && !r_inflight) begin
            r_state     <= IDLE;
            r_i_count   <= '0;
            r_idle_done <= (r_i_count == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
